// File: rtl/adder_pkg.sv
// Shared definitions for the sequential slice adder: FSM states, slice width, counter sizing.
// Latency: none (package only).
// Backpressure: none (package only).
package adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int SLICE_W = 4;

   // Slice counter width: ceil(log2(nslice)), never narrower than one bit.
   function automatic int cnt_width(input int nslice);
      return (nslice > 1) ? $clog2(nslice) : 1;
   endfunction

endpackage

// File: rtl/adder_4bit.sv
// 4-bit ripple adder used as the shared slice datapath.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs directly.
module adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] total;

   // Five-bit add so the slice carry-out falls out of the top bit.
   always_comb begin
      total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      sum   = total[3:0];
      cout  = total[4];
   end

endmodule

// File: rtl/adder_seq_16bit.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit slice adder, LSB slice first.
// Latency: result valid WIDTH/4 cycles after the accept edge; one op per WIDTH/4+2 cycles.
// Backpressure: holds the result in DONE with in_ready low until out_ready is seen.
module adder_seq_16bit
   import adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din_one,
   input  logic [WIDTH-1:0] din_two,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int CNT_W  = cnt_width(NSLICE);
   localparam int RES_W  = WIDTH - SLICE_W;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

   state_t             state;
   logic [WIDTH-1:0]   op_one;
   logic [WIDTH-1:0]   op_two;
   logic [RES_W-1:0]   res;
   logic               carry_q;
   logic [CNT_W-1:0]   cnt;

   logic [SLICE_W-1:0] slice_sum;
   logic               slice_cout;
   logic [WIDTH-1:0]   res_shift;

   // Operands shift right each CALC cycle, so the active slice is always the low nibble.
   adder_4bit u_slice (
      .a    (op_one[SLICE_W-1:0]),
      .b    (op_two[SLICE_W-1:0]),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // The result register only holds the slices already finished; the current slice
   // enters at the top, so on the last slice this vector is the complete sum.
   always_comb begin
      res_shift = {slice_sum, res};
   end

   // Control FSM with registered handshake outputs and the slice datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         carry_q   <= 1'b0;
         cnt       <= '0;
         op_one    <= '0;
         op_two    <= '0;
         res       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  op_one   <= din_one;
                  op_two   <= din_two;
                  carry_q  <= cin;
                  cnt      <= '0;
                  res      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_CALC;
               end
            end
            ST_CALC: begin
               op_one  <= op_one >> SLICE_W;
               op_two  <= op_two >> SLICE_W;
               res     <= res_shift[WIDTH-1:SLICE_W];
               carry_q <= slice_cout;
               cnt     <= cnt + 1'b1;
               if (cnt == LAST) begin
                  sum       <= res_shift;
                  cout      <= slice_cout;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_seq_16bit.sv
// Scoreboard bench for the sequential slice adder at WIDTH=16 and WIDTH=8.
// Latency: checks result timing against the accept edge and throughput with in_valid held.
// Backpressure: exercises stalled DONE with random and fixed out_ready patterns.
module tb_adder_seq_16bit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=16 instance
   logic        rst, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
   logic [15:0] din_one, din_two, sum;
   // WIDTH=8 instance
   logic        rst8, in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
   logic [7:0]  din_one8, din_two8, sum8;

   adder_seq_16bit #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .din_one(din_one), .din_two(din_two), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   adder_seq_16bit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
      .din_one(din_one8), .din_two(din_two8), .cin(cin8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .cout(cout8), .busy(busy8)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      logic [16:0] res;
      int          acc;
   } exp_t;

   exp_t q16[$];
   exp_t q8[$];
   exp_t e16, e8;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // out_ready for the 16-bit instance: either fixed or randomly toggled
   bit ordy_rand = 1'b0;
   bit ordy_val  = 1'b1;
   always @(posedge clk) begin
      #1;
      out_ready = ordy_rand ? 1'($urandom_range(0, 1)) : ordy_val;
   end

   // Monitor for the 16-bit instance
   bit prev_ov16 = 1'b0;
   bit prev_hs16 = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_ov16 = 1'b0;
         prev_hs16 = 1'b0;
      end else begin
         if (prev_hs16) begin
            check("in_ready16 after handshake", 32'(in_ready), 32'd1);
            check("out_valid16 drop after handshake", 32'(out_valid), 32'd0);
         end
         if (out_valid && !prev_ov16) begin
            if (q16.size() == 0) fail("out_valid16 with no pending operation");
            else check("latency16", 32'(cyc - q16[0].acc), 32'd4);
         end
         if (out_valid) check("busy16 in DONE", 32'(busy), 32'd1);
         prev_hs16 = out_valid && out_ready;
         if (prev_hs16 && q16.size() > 0) begin
            e16 = q16.pop_front();
            check("result16 {cout,sum}", 32'({cout, sum}), 32'(e16.res));
         end
         prev_ov16 = out_valid;
      end
   end

   // Monitor for the 8-bit instance
   bit prev_ov8 = 1'b0;
   bit prev_hs8 = 1'b0;
   always @(negedge clk) begin
      if (rst8) begin
         prev_ov8 = 1'b0;
         prev_hs8 = 1'b0;
      end else begin
         if (prev_hs8) check("in_ready8 after handshake", 32'(in_ready8), 32'd1);
         if (out_valid8 && !prev_ov8) begin
            if (q8.size() == 0) fail("out_valid8 with no pending operation");
            else check("latency8", 32'(cyc - q8[0].acc), 32'd2);
         end
         prev_hs8 = out_valid8 && out_ready8;
         if (prev_hs8 && q8.size() > 0) begin
            e8 = q8.pop_front();
            check("result8 {cout,sum}", 32'({cout8, sum8}), 32'(e8.res));
         end
         prev_ov8 = out_valid8;
      end
   end

   // Issue one 16-bit operation; called and returns at posedge+1.
   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c);
      int t = 0;
      din_one  = a;
      din_two  = b;
      cin      = c;
      in_valid = 1'b1;
      while (!in_ready && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) begin
         fail("op16 accept timeout");
      end else begin
         q16.push_back('{res: ({1'b0, a} + {1'b0, b} + 17'(c)), acc: cyc + 1});
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle16();
      int t = 0;
      while ((q16.size() != 0 || !in_ready) && t < 1000) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 1000) fail("wait_idle16 timeout");
   endtask

   task automatic wait_idle8();
      int t = 0;
      while ((q8.size() != 0 || !in_ready8) && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 500) fail("wait_idle8 timeout");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int  t;
      int  k;
      int  last;
      logic [7:0] a8, b8;
      logic       c8;

      rst = 1'b1; in_valid = 1'b0; din_one = '0; din_two = '0; cin = 1'b0;
      rst8 = 1'b1; in_valid8 = 1'b0; din_one8 = '0; din_two8 = '0; cin8 = 1'b0;
      out_ready8 = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      check("reset in_ready16", 32'(in_ready), 32'd1);
      check("reset out_valid16", 32'(out_valid), 32'd0);
      check("reset busy16", 32'(busy), 32'd0);
      check("reset {cout,sum}16", 32'({cout, sum}), 32'd0);
      check("reset in_ready8", 32'(in_ready8), 32'd1);
      check("reset {cout,sum}8", 32'({cout8, sum8}), 32'd0);
      rst = 1'b0;
      rst8 = 1'b0;
      @(posedge clk); #1;

      // Directed sums
      op16(16'h1234, 16'h4321, 1'b0);
      wait_idle16();
      check("sum kept after return to idle", 32'(sum), 32'h5555);
      op16(16'hFFFF, 16'h0001, 1'b0);
      op16(16'hFFFF, 16'hFFFF, 1'b1);
      wait_idle16();

      // Backpressure with stray in_valid pulses during the stall
      ordy_val = 1'b0;
      @(posedge clk); #1;
      op16(16'h00FF, 16'h0001, 1'b0);
      t = 0;
      while (!out_valid && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!out_valid) fail("backpressure out_valid timeout");
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2 == 0);
         din_one  = 16'($urandom);
         din_two  = 16'($urandom);
         cin      = 1'($urandom);
         @(posedge clk); #1;
         check("stall in_ready16", 32'(in_ready), 32'd0);
         check("stall out_valid16", 32'(out_valid), 32'd1);
         check("stall {cout,sum}16", 32'({cout, sum}), 32'h00100);
      end
      in_valid = 1'b0;
      ordy_val = 1'b1;
      wait_idle16();

      // Reset during the second CALC cycle aborts the operation
      op16(16'h0AAA, 16'h0555, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      if (q16.size() > 0) void'(q16.pop_back());
      check("abort in_ready16", 32'(in_ready), 32'd1);
      check("abort out_valid16", 32'(out_valid), 32'd0);
      check("abort busy16", 32'(busy), 32'd0);
      check("abort {cout,sum}16", 32'({cout, sum}), 32'd0);
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      op16(16'h0001, 16'h0002, 1'b0);
      wait_idle16();

      // Random operations with random out_ready
      ordy_rand = 1'b1;
      repeat (40) op16(16'($urandom), 16'($urandom), 1'($urandom));
      wait_idle16();
      ordy_rand = 1'b0;
      @(posedge clk); #1;

      // WIDTH=8 directed: carry out of the top slice
      din_one8 = 8'hF0; din_two8 = 8'h10; cin8 = 1'b0; in_valid8 = 1'b1;
      t = 0;
      while (!in_ready8 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      q8.push_back('{res: 17'h00100, acc: cyc + 1});
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      wait_idle8();

      // WIDTH=8 back-to-back with in_valid held high: one accept every 4 cycles
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      din_one8 = a8; din_two8 = b8; cin8 = c8; in_valid8 = 1'b1;
      k = 0; last = -1; t = 0;
      while (k < 6 && t < 100) begin
         if (in_ready8) begin
            q8.push_back('{res: 17'({1'b0, a8} + {1'b0, b8} + 9'(c8)), acc: cyc + 1});
            if (last >= 0) check("throughput8 accept spacing", 32'(cyc + 1 - last), 32'd4);
            last = cyc + 1;
            k++;
            @(posedge clk); #1;
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            din_one8 = a8; din_two8 = b8; cin8 = c8;
         end else begin
            @(posedge clk); #1;
         end
         t++;
      end
      in_valid8 = 1'b0;
      if (k < 6) fail("throughput8 accept timeout");
      wait_idle8();

      check("queue16 drained", 32'(q16.size()), 32'd0);
      check("queue8 drained", 32'(q8.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
